// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall handling and the IF/ID pipeline register.
// Also keeps a sticky misaligned-target flag and a count of instructions handed to decode.
module fetch_stage #(
   parameter int ADDR_SIZE = 32,
   parameter int MEM_WIDTH = 32,
   parameter logic [ADDR_SIZE-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [1:0]           pc_src,
   input  logic [ADDR_SIZE-1:0] branch_target,
   input  logic [ADDR_SIZE-1:0] jump_target,
   output logic [ADDR_SIZE-1:0] Instruction_addr,
   input  logic [MEM_WIDTH-1:0] Instruction_Data,
   output logic [MEM_WIDTH-1:0] IF_ID_Instruction,
   output logic [ADDR_SIZE-1:0] IF_ID_PC_plus4,
   output logic                 IF_ID_valid,
   output logic                 align_err,
   output logic [31:0]          fetch_count
);

   logic [ADDR_SIZE-1:0] pc;
   logic [ADDR_SIZE-1:0] pc_plus4;
   logic [ADDR_SIZE-1:0] target;
   logic                 redirect;
   logic                 misaligned;
   logic                 load_if_id;

   // pc_src 11 deliberately falls through to sequential fetch, like 00.
   always_comb begin
      redirect   = (pc_src == 2'b01) || (pc_src == 2'b10);
      target     = (pc_src == 2'b01) ? branch_target : jump_target;
      misaligned = redirect && (target[1:0] != 2'b00);
      pc_plus4   = pc + ADDR_SIZE'(4);
      load_if_id = !flush && !stall;
   end

   assign Instruction_addr = pc;

   // A redirect overrides stall so a taken branch is never lost behind a hazard hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= {target[ADDR_SIZE-1:2], 2'b00};
      end else if (!stall) begin
         pc <= pc_plus4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         IF_ID_Instruction <= '0;
         IF_ID_PC_plus4    <= '0;
         IF_ID_valid       <= 1'b0;
      end else if (flush) begin
         IF_ID_Instruction <= '0;
         IF_ID_PC_plus4    <= '0;
         IF_ID_valid       <= 1'b0;
      end else if (!stall) begin
         IF_ID_Instruction <= Instruction_Data;
         IF_ID_PC_plus4    <= pc_plus4;
         IF_ID_valid       <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         align_err   <= 1'b0;
         fetch_count <= '0;
      end else begin
         if (misaligned) begin
            align_err <= 1'b1;
         end
         if (load_if_id) begin
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a rule-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [1:0]  pc_src;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] instr_addr;
   logic [31:0] instr_data;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        align_err;
   logic [31:0] fetch_count;

   int num_checks = 0;
   int num_errors = 0;
   bit checking_on = 0;

   fetch_stage #(
      .ADDR_SIZE(32),
      .MEM_WIDTH(32),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .flush(flush),
      .pc_src(pc_src),
      .branch_target(branch_target),
      .jump_target(jump_target),
      .Instruction_addr(instr_addr),
      .Instruction_Data(instr_data),
      .IF_ID_Instruction(if_id_instr),
      .IF_ID_PC_plus4(if_id_pc4),
      .IF_ID_valid(if_id_valid),
      .align_err(align_err),
      .fetch_count(fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents are a pure function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd0) return 32'h0109_8820;
      if (a == 32'd4) return 32'hAC11_0004;
      if (a < 32'd256) return 32'h1000_0000 + (a >> 2);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   assign instr_data = mem_word(instr_addr);

   // Reference model: expected architectural state after each edge.
   logic [31:0] m_pc, m_instr, m_pc4, m_count;
   logic        m_valid, m_align;
   logic        m_redirect;
   logic [31:0] m_target;

   assign m_redirect = (pc_src == 2'd1) || (pc_src == 2'd2);
   assign m_target   = (pc_src == 2'd1) ? branch_target : jump_target;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc    <= 32'd0;
         m_instr <= 32'd0;
         m_pc4   <= 32'd0;
         m_valid <= 1'b0;
         m_align <= 1'b0;
         m_count <= 32'd0;
      end else begin
         if (m_redirect) begin
            m_pc <= m_target & 32'hFFFF_FFFC;
            if (m_target % 4 != 0) m_align <= 1'b1;
         end else if (!stall) begin
            m_pc <= m_pc + 32'd4;
         end
         if (flush) begin
            m_instr <= 32'd0;
            m_pc4   <= 32'd0;
            m_valid <= 1'b0;
         end else if (!stall) begin
            m_instr <= mem_word(m_pc);
            m_pc4   <= m_pc + 32'd4;
            m_valid <= 1'b1;
            m_count <= m_count + 32'd1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking_on && !rst) begin
         checkOutput("model_addr", instr_addr, m_pc);
         checkOutput("model_instr", if_id_instr, m_instr);
         checkOutput("model_pc4", if_id_pc4, m_pc4);
         checkOutput("model_valid", 32'(if_id_valid), 32'(m_valid));
         checkOutput("model_align", 32'(align_err), 32'(m_align));
         checkOutput("model_count", fetch_count, m_count);
      end
   end

   // Drive one cycle of inputs from a negedge, then return at the following negedge.
   task automatic applyStimulus(input logic st, input logic fl, input logic [1:0] src,
                                input logic [31:0] bt, input logic [31:0] jt);
      stall         = st;
      flush         = fl;
      pc_src        = src;
      branch_target = bt;
      jump_target   = jt;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      pc_src = 2'b00;
      branch_target = 32'd0;
      jump_target = 32'd0;
      repeat (2) @(negedge clk);
      checkOutput("reset_addr", instr_addr, 32'd0);
      checkOutput("reset_valid", 32'(if_id_valid), 32'd0);
      checkOutput("reset_count", fetch_count, 32'd0);
      checkOutput("reset_align", 32'(align_err), 32'd0);
      rst = 1'b0;
      checking_on = 1;

      // Sequential fetch from address 0
      applyStimulus(0, 0, 2'b00, 32'd0, 32'd0);
      checkOutput("seq1_instr", if_id_instr, 32'h0109_8820);
      checkOutput("seq1_pc4", if_id_pc4, 32'd4);
      checkOutput("seq1_valid", 32'(if_id_valid), 32'd1);
      checkOutput("seq1_addr", instr_addr, 32'd4);
      applyStimulus(0, 0, 2'b00, 32'd0, 32'd0);
      checkOutput("seq2_instr", if_id_instr, 32'hAC11_0004);
      checkOutput("seq2_count", fetch_count, 32'd2);

      // Two-cycle stall at PC 8
      repeat (2) applyStimulus(1, 0, 2'b00, 32'd0, 32'd0);
      checkOutput("stall_addr", instr_addr, 32'd8);
      checkOutput("stall_instr", if_id_instr, 32'hAC11_0004);
      checkOutput("stall_count", fetch_count, 32'd2);
      applyStimulus(0, 0, 2'b00, 32'd0, 32'd0);
      checkOutput("release_instr", if_id_instr, 32'h1000_0002);
      checkOutput("release_addr", instr_addr, 32'd12);
      repeat (2) applyStimulus(0, 0, 2'b00, 32'd0, 32'd0);
      checkOutput("pre_branch_addr", instr_addr, 32'd20);

      // Taken branch with flush
      applyStimulus(0, 1, 2'b01, 32'd28, 32'd0);
      checkOutput("branch_addr", instr_addr, 32'd28);
      checkOutput("branch_valid", 32'(if_id_valid), 32'd0);
      checkOutput("branch_instr", if_id_instr, 32'd0);
      checkOutput("branch_count", fetch_count, 32'd5);
      applyStimulus(0, 0, 2'b00, 32'd0, 32'd0);
      checkOutput("target_instr", if_id_instr, 32'h1000_0007);
      checkOutput("target_valid", 32'(if_id_valid), 32'd1);

      // pc_src 11 is sequential and never flags misaligned targets
      applyStimulus(0, 0, 2'b11, 32'h55, 32'h77);
      checkOutput("src11_addr", instr_addr, 32'd36);
      checkOutput("src11_align", 32'(align_err), 32'd0);

      // Stall + flush + misaligned jump
      applyStimulus(1, 1, 2'b10, 32'd0, 32'h0000_0039);
      checkOutput("prio_addr", instr_addr, 32'h38);
      checkOutput("prio_valid", 32'(if_id_valid), 32'd0);
      checkOutput("prio_pc4", if_id_pc4, 32'd0);
      checkOutput("prio_align", 32'(align_err), 32'd1);
      checkOutput("prio_count", fetch_count, 32'd7);
      repeat (10) applyStimulus(0, 0, 2'b00, 32'd0, 32'd0);
      checkOutput("sticky_align", 32'(align_err), 32'd1);
      checkOutput("sticky_addr", instr_addr, 32'h60);
      checkOutput("sticky_count", fetch_count, 32'd17);

      // PC wrap at the top of the address space
      applyStimulus(0, 1, 2'b10, 32'd0, 32'hFFFF_FFFC);
      checkOutput("wrap_pc", instr_addr, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 2'b00, 32'd0, 32'd0);
      checkOutput("wrap_addr", instr_addr, 32'd0);
      checkOutput("wrap_pc4", if_id_pc4, 32'd0);
      checkOutput("wrap_instr", if_id_instr, 32'hFFFF_FFFC ^ 32'hDEAD_BEEF);
      applyStimulus(0, 0, 2'b00, 32'd0, 32'd0);

      // Asynchronous reset between edges, mid-stall
      stall = 1'b1;
      #2 rst = 1'b1;
      #1;
      checkOutput("areset_addr", instr_addr, 32'd0);
      checkOutput("areset_instr", if_id_instr, 32'd0);
      checkOutput("areset_pc4", if_id_pc4, 32'd0);
      checkOutput("areset_valid", 32'(if_id_valid), 32'd0);
      checkOutput("areset_align", 32'(align_err), 32'd0);
      checkOutput("areset_count", fetch_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 0, 2'b00, 32'd0, 32'd0);
      checkOutput("post_reset_instr", if_id_instr, 32'h0109_8820);
      checkOutput("post_reset_count", fetch_count, 32'd1);

      checking_on = 0;
      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_SIZE, default 32: PC and address width.
REQ-002 Parameter MEM_WIDTH, default 32: instruction word width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value on reset.
REQ-004 The clock port SHALL be: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 The reset port SHALL be: rst  input  1  reset, asynchronous and active-high.
REQ-006 stall  input  1  hazard hold of PC and IF/ID.
REQ-007 flush  input  1  squash the IF/ID contents.
REQ-008 pc_src  input  2  next-PC select: 00 = PC+4, 01 = branch_target, 10 = jump_target, 11 = PC+4.
REQ-009 branch_target  input  ADDR_SIZE  branch redirect address.
REQ-010 jump_target  input  ADDR_SIZE  jump redirect address.
REQ-011 Instruction_addr  output  ADDR_SIZE  current PC, driven to the instruction memory.
REQ-012 Instruction_Data  input  MEM_WIDTH  combinational instruction-memory read data for Instruction_addr.
REQ-013 IF_ID_Instruction  output  MEM_WIDTH  registered instruction to decode.
REQ-014 IF_ID_PC_plus4  output  ADDR_SIZE  registered PC+4 of that instruction.
REQ-015 IF_ID_valid  output  1  IF/ID holds a real instruction.
REQ-016 align_err  output  1  sticky flag: a misaligned redirect target was received.
REQ-017 fetch_count  output  32  number of instructions loaded into IF/ID.

Function
REQ-018 Instruction_addr SHALL equal the PC register combinationally.
REQ-019 Redirect SHALL mean pc_src = 01 or 10; the next PC is the selected target with bits [1:0] forced to 0.
REQ-020 If redirect is asserted, the PC SHALL load the target regardless of stall (redirect beats stall).
REQ-021 If there is no redirect and stall = 0, the PC SHALL load PC+4, computed modulo 2^ADDR_SIZE (32'hFFFF_FFFC wraps to 0).
REQ-022 If there is no redirect and stall = 1, the PC SHALL hold.
REQ-023 If flush = 1, IF/ID SHALL load IF_ID_Instruction = 0 (nop), IF_ID_PC_plus4 = 0 and IF_ID_valid = 0; flush beats stall.
REQ-024 If flush = 0 and stall = 1, IF/ID SHALL hold all fields.
REQ-025 If flush = 0 and stall = 0, IF/ID SHALL load Instruction_Data, PC+4 and valid = 1.
REQ-026 Fetch latency SHALL be one cycle: the word at address PC appears on IF_ID_Instruction after the next rising edge.
REQ-027 align_err SHALL set on any edge where the selected redirect target has bits [1:0] != 0, and SHALL stay set until reset.
REQ-028 fetch_count SHALL increment by 1 on each edge where IF/ID loads with valid = 1, wrapping from 32'hFFFF_FFFF to 0; it SHALL not increment on stall or flush.
REQ-029 Simultaneous flush and redirect (the normal taken-branch case) SHALL both take effect on the same edge.

Reset
REQ-030 While rst = 1 the outputs SHALL be, immediately and without waiting for clk:
- PC = RESET_PC;
- IF_ID_Instruction = 0, IF_ID_PC_plus4 = 0, IF_ID_valid = 0;
- align_err = 0, fetch_count = 0.
REQ-031 Assertion of rst mid-operation, including mid-stall, SHALL abandon all state.
REQ-032 On the first rising edge after rst deasserts, the block SHALL fetch from RESET_PC.

Verification
REQ-033 Sequential fetch:
- stimulus: reset, memory word 0 = 32'h01098820, word 1 = 32'hAC110004, stall = flush = 0, pc_src = 00;
- edge 1 after reset: IF_ID_Instruction = 32'h01098820, IF_ID_PC_plus4 = 4, valid = 1, Instruction_addr = 4;
- edge 2: IF_ID_Instruction = 32'hAC110004, fetch_count = 2.
REQ-034 Stall:
- stimulus: stall = 1 for 2 cycles at PC = 8;
- response: PC stays 8, IF/ID unchanged, fetch_count unchanged;
- after release: the word at 8 is loaded.
REQ-035 Taken branch:
- stimulus: at PC = 20, pc_src = 01, branch_target = 28, flush = 1;
- next edge: PC = 28, IF_ID_valid = 0, IF_ID_Instruction = 0;
- following edge: word at 28 is loaded, valid = 1.
REQ-036 Priority and alignment:
- stimulus: stall = 1, flush = 1, pc_src = 10, jump_target = 32'h0000_0039;
- response: PC = 32'h38, IF/ID squashed, align_err = 1, and align_err is still 1 after 10 more cycles.
REQ-037 Wrap: with PC = 32'hFFFF_FFFC and no stall, next PC = 0 and IF_ID_PC_plus4 = 0.
REQ-038 Async reset: assert rst between clock edges while valid = 1 -> all outputs return to reset values before the next edge.
